fifo_stream_reader: RTL

//  Downstream drain stage for the 8-deep sync FIFO. Drives the FIFO's rd_en,

---
 rtl/fifo_stream_reader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Drain stage for the 8-deep sync FIFO: issues fifo_rd_en and turns the
// one-cycle read latency into a valid/ready stream through a 2-entry skid buffer.
// Optional accepted-beat counter rd_count is built only when FIFO_RD_CNT_EN is defined.
module fifo_stream_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_rd_en,
  input  logic              flush,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  rd_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e              state_q;
  logic              inflight_q;
  logic              m_valid_q;
  logic [DATA_W-1:0] entry0_q;
  logic [DATA_W-1:0] entry1_q;

  logic       pop;
  logic       grant;
  logic [1:0] occ;
  logic [1:0] pending;

  assign pop     = m_valid_q & m_ready;
  assign occ     = state_q;
  assign pending = occ + {1'b0, inflight_q};

  // A read may be issued into a full (buffered + in-flight) skid buffer only when
  // a beat leaves this same cycle; this is the m_ready -> fifo_rd_en comb path.
  assign fifo_rd_en = ~fifo_empty & ~flush &
                      ((pending < 2'd2) | ((pending == 2'd2) & pop));
  assign grant      = fifo_rd_en & ~fifo_empty;

  assign m_valid = m_valid_q;
  assign m_data  = entry0_q;

  // NOTE: sequential state is written with <= only, so every branch below reads
  // the pre-edge values of state_q/entry1_q regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      m_valid_q  <= 1'b0;
      // NOTE: the two data entries are reset because m_data is defined as 0
      // out of reset; without that requirement they could be left unreset.
      entry0_q   <= '0;
      entry1_q   <= '0;
    end else begin
      inflight_q <= grant;
      if (flush) begin
        state_q   <= EMPTY;
        m_valid_q <= 1'b0;
      end else begin
        case (state_q)
          EMPTY: begin
            if (inflight_q) begin
              entry0_q  <= fifo_rdata;
              state_q   <= ONE;
              m_valid_q <= 1'b1;
            end
          end
          ONE: begin
            if (inflight_q && pop) begin
              entry0_q <= fifo_rdata;
            end else if (inflight_q) begin
              entry1_q <= fifo_rdata;
              state_q  <= TWO;
            end else if (pop) begin
              state_q   <= EMPTY;
              m_valid_q <= 1'b0;
            end
          end
          TWO: begin
            if (pop) begin
              entry0_q <= entry1_q;
              state_q  <= ONE;
            end
          end
          default: begin
            state_q   <= EMPTY;
            m_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (pop && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign rd_count = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign rd_count       = '0;
`endif

endmodule
